// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - opcode, funct and state encodings shared by the sequencer and control LUT
package cpu_ctrl_pkg;

  typedef enum logic [5:0] {
    ST_IF   = 6'd0,
    ST_ID   = 6'd1,
    ST_EXEC = 6'd2,
    ST_MEM  = 6'd3,
    ST_WB   = 6'd4,
    ST_HALT = 6'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

endpackage

// File: rtl/mc_next_state_decode.sv
// rtl/mc_next_state_decode.sv - combinational next-state and illegal-instruction decode
module mc_next_state_decode
  import cpu_ctrl_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output state_e     next_state,
  output logic       illegal_hit
);

  always_comb begin
    next_state  = state;
    illegal_hit = 1'b0;
    case (state)
      ST_IF: begin
        if (mem_ready) next_state = ST_ID;
      end
      ST_ID: begin
        case (opcode)
          OP_J: next_state = ST_IF;
          OP_RTYPE: begin
            case (funct)
              FN_ADD, FN_SUB, FN_SLT, FN_JR: next_state = ST_EXEC;
              default: begin
                next_state  = ST_HALT;
                illegal_hit = 1'b1;
              end
            endcase
          end
          OP_LW, OP_SW, OP_JAL, OP_BEQ, OP_BNE, OP_XORI, OP_ADDI: next_state = ST_EXEC;
          default: begin
            next_state  = ST_HALT;
            illegal_hit = 1'b1;
          end
        endcase
      end
      ST_EXEC: begin
        case (opcode)
          OP_LW, OP_SW, OP_BEQ, OP_BNE: next_state = ST_MEM;
          OP_RTYPE: next_state = (funct == FN_JR) ? ST_IF : ST_WB;
          default: next_state = ST_WB;
        endcase
      end
      ST_MEM: begin
        // Branches resolve here in one cycle; loads and stores wait on memory.
        case (opcode)
          OP_LW:   next_state = mem_ready ? ST_WB : ST_MEM;
          OP_SW:   next_state = mem_ready ? ST_IF : ST_MEM;
          default: next_state = ST_IF;
        endcase
      end
      ST_WB:   next_state = ST_IF;
      ST_HALT: next_state = ST_HALT;
      default: next_state = ST_IF;
    endcase
  end

endmodule

// File: rtl/mc_state_sequencer.sv
// rtl/mc_state_sequencer.sv - multi-cycle CPU state/instruction register, PC enable, counters and trap
module mc_state_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int STATE_W = 6,
  parameter int DATA_W  = 32,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mem_ready,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               ir_we,
  input  logic               pc_we_req,
  input  logic               ben,
  input  logic               beqbne,
  input  logic               alu_zero,
  output logic [STATE_W-1:0] state,
  output logic [DATA_W-1:0]  instruction,
  output logic               pc_en,
  output logic               illegal,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [CNT_W-1:0]   retire_cnt
);

  state_e              r_state;
  logic [DATA_W-1:0]   r_instr;
  logic                r_illegal;
  logic [CNT_W-1:0]    r_cycle;
  logic [CNT_W-1:0]    r_retire;

  state_e              w_next_state;
  logic                w_illegal_hit;
  logic                w_fetch;
  logic                w_dec_ready;
  logic                w_retire;

  assign w_fetch     = (r_state == ST_IF) & ir_we & mem_ready;
  // In IF the decoder only advances when the instruction is actually captured.
  assign w_dec_ready = (r_state == ST_IF) ? w_fetch : mem_ready;
  assign w_retire    = (w_next_state == ST_IF) & (r_state != ST_IF) & (r_state != ST_HALT);

  mc_next_state_decode u_decode (
    .state       (r_state),
    .opcode      (r_instr[DATA_W-1 -: 6]),
    .funct       (r_instr[5:0]),
    .mem_ready   (w_dec_ready),
    .next_state  (w_next_state),
    .illegal_hit (w_illegal_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IF;
      r_instr   <= '0;
      r_illegal <= 1'b0;
      r_cycle   <= '0;
      r_retire  <= '0;
    end else begin
      r_state <= w_next_state;
      r_cycle <= r_cycle + CNT_W'(1);
      if (w_fetch)       r_instr   <= mem_rdata;
      if (w_illegal_hit) r_illegal <= 1'b1;
      if (w_retire)      r_retire  <= r_retire + CNT_W'(1);
    end
  end

  assign pc_en       = (r_state != ST_HALT) & (pc_we_req | (ben & (alu_zero ^ beqbne)));
  assign state       = STATE_W'(r_state);
  assign instruction = r_instr;
  assign illegal     = r_illegal;
  assign cycle_cnt   = r_cycle;
  assign retire_cnt  = r_retire;

endmodule

// File: tb/tb_mc_state_sequencer.sv
// tb/tb_mc_state_sequencer.sv - randomized self-checking bench for mc_state_sequencer
module tb_mc_state_sequencer;

  localparam int CW = 8;
  localparam int S_IF = 0, S_ID = 1, S_EXEC = 2, S_MEM = 3, S_WB = 4, S_HALT = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_ready = 1'b0;
  logic [31:0]   mem_rdata = '0;
  logic          ir_we = 1'b0;
  logic          pc_we_req = 1'b0;
  logic          ben = 1'b0;
  logic          beqbne = 1'b0;
  logic          alu_zero = 1'b0;
  logic [5:0]    state;
  logic [31:0]   instruction;
  logic          pc_en;
  logic          illegal;
  logic [CW-1:0] cycle_cnt;
  logic [CW-1:0] retire_cnt;

  int n_pass = 0;
  int n_total = 0;
  logic [CW-1:0] exp_cycle, exp_retire;
  logic [31:0]   exp_instr;
  int path_q[$];

  mc_state_sequencer #(.STATE_W(6), .DATA_W(32), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .ir_we(ir_we), .pc_we_req(pc_we_req), .ben(ben), .beqbne(beqbne), .alu_zero(alu_zero),
    .state(state), .instruction(instruction), .pc_en(pc_en), .illegal(illegal),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  // Visited states of a legal instruction, IF first; the step after the last one is IF again.
  function automatic void build_path(input logic [31:0] ins);
    path_q = {S_IF, S_ID};
    case (ins[31:26])
      6'h02: ;
      6'h00: if (ins[5:0] == 6'h08) path_q.push_back(S_EXEC);
             else begin path_q.push_back(S_EXEC); path_q.push_back(S_WB); end
      6'h23: begin path_q.push_back(S_EXEC); path_q.push_back(S_MEM); path_q.push_back(S_WB); end
      6'h2B, 6'h04, 6'h05: begin path_q.push_back(S_EXEC); path_q.push_back(S_MEM); end
      default: begin path_q.push_back(S_EXEC); path_q.push_back(S_WB); end
    endcase
  endfunction

  function automatic logic [31:0] rand_legal();
    logic [5:0] ops[9] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0E, 6'h23, 6'h2B};
    logic [5:0] fns[4] = '{6'h20, 6'h22, 6'h2A, 6'h08};
    logic [31:0] w;
    w = $urandom;
    w[31:26] = ops[$urandom_range(0, 8)];
    if (w[31:26] == 6'h00) w[5:0] = fns[$urandom_range(0, 3)];
    return w;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    {ir_we, mem_ready, pc_we_req, ben, beqbne, alu_zero} = '0;
    mem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    exp_cycle = 1; exp_retire = 0; exp_instr = '0;
  endtask

  // Drives one instruction to completion with if_st fetch stalls and mem_st memory stalls.
  task automatic run_instr(input logic [31:0] ins, input int if_st, input int mem_st);
    int idx, cur, if_left, mem_left;
    bit adv, memw;
    logic exp_pc;
    build_path(ins);
    idx = 0; if_left = if_st; mem_left = mem_st;
    memw = (ins[31:26] == 6'h23) || (ins[31:26] == 6'h2B);
    for (int guard = 0; guard < 100; guard++) begin
      @(negedge clk);
      cur = path_q[idx];
      adv = 1'b1;
      {ir_we, mem_ready, pc_we_req, ben, beqbne, alu_zero} = 6'($urandom);
      mem_rdata = $urandom;
      if (cur == S_IF) begin
        mem_rdata = ins;
        if (if_left > 0) begin mem_ready = 1'b0; if_left--; adv = 1'b0; end
        else begin mem_ready = 1'b1; ir_we = 1'b1; end
      end else if (cur == S_MEM && memw) begin
        if (mem_left > 0) begin mem_ready = 1'b0; mem_left--; adv = 1'b0; end
        else mem_ready = 1'b1;
      end
      exp_pc = pc_we_req | (ben & (alu_zero != beqbne));
      #1;
      n_total++; if (state !== 6'(cur)) $display("FAIL run_state ins=%h act=%0d exp=%0d", ins, state, cur); else n_pass++;
      n_total++; if (instruction !== exp_instr) $display("FAIL run_ir act=%h exp=%h", instruction, exp_instr); else n_pass++;
      n_total++; if (illegal !== 1'b0) $display("FAIL run_illegal act=%b exp=0", illegal); else n_pass++;
      n_total++; if (cycle_cnt !== exp_cycle) $display("FAIL run_cycle act=%0d exp=%0d", cycle_cnt, exp_cycle); else n_pass++;
      n_total++; if (retire_cnt !== exp_retire) $display("FAIL run_retire act=%0d exp=%0d", retire_cnt, exp_retire); else n_pass++;
      n_total++; if (pc_en !== exp_pc) $display("FAIL run_pc_en act=%b exp=%b", pc_en, exp_pc); else n_pass++;
      @(posedge clk);
      exp_cycle++;
      if (adv) begin
        if (cur == S_IF) exp_instr = ins;
        idx++;
        if (idx == path_q.size()) begin
          exp_retire++;
          return;
        end
      end
    end
    n_total++;
    $display("FAIL run_timeout ins=%h stuck at step act=%0d exp=%0d", ins, idx, path_q.size());
  endtask

  task automatic test_reset();
    #3;
    n_total++; if (state !== 6'd0) $display("FAIL reset_state act=%0d exp=0", state); else n_pass++;
    n_total++; if (instruction !== 32'd0) $display("FAIL reset_ir act=%h exp=0", instruction); else n_pass++;
    n_total++; if (illegal !== 1'b0) $display("FAIL reset_illegal act=%b exp=0", illegal); else n_pass++;
    #5;
    n_total++; if (cycle_cnt !== 8'd0) $display("FAIL reset_cycle act=%0d exp=0", cycle_cnt); else n_pass++;
    n_total++; if (retire_cnt !== 8'd0) $display("FAIL reset_retire act=%0d exp=0", retire_cnt); else n_pass++;
    do_reset();
  endtask

  task automatic test_add();
    do_reset();
    run_instr(32'h012A4020, 0, 0);
    @(negedge clk); #1;
    n_total++; if (state !== 6'd0) $display("FAIL add_state act=%0d exp=0", state); else n_pass++;
    n_total++; if (retire_cnt !== 8'd1) $display("FAIL add_retire act=%0d exp=1", retire_cnt); else n_pass++;
    n_total++; if (cycle_cnt !== 8'd5) $display("FAIL add_cycle act=%0d exp=5", cycle_cnt); else n_pass++;
  endtask

  task automatic test_lw_stall();
    do_reset();
    run_instr(32'h8D280004, 0, 3);
    @(negedge clk); #1;
    n_total++; if (retire_cnt !== 8'd1) $display("FAIL lw_retire act=%0d exp=1", retire_cnt); else n_pass++;
    n_total++; if (cycle_cnt !== 8'd9) $display("FAIL lw_cycle act=%0d exp=9", cycle_cnt); else n_pass++;
  endtask

  task automatic test_branch();
    logic [31:0] words[2] = '{32'h11090003, 32'h15090003};
    do_reset();
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      ir_we = 1'b1; mem_ready = 1'b1; mem_rdata = words[b]; ben = 1'b0; pc_we_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      ir_we = 1'b0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      ben = 1'b1; beqbne = 1'(b); alu_zero = (b == 0);
      #1;
      n_total++; if (state !== 6'd3) $display("FAIL br%0d_mem_state act=%0d exp=3", b, state); else n_pass++;
      n_total++; if (pc_en !== 1'b1) $display("FAIL br%0d_taken act=%b exp=1", b, pc_en); else n_pass++;
      alu_zero = (b != 0);
      #1;
      n_total++; if (pc_en !== 1'b0) $display("FAIL br%0d_not_taken act=%b exp=0", b, pc_en); else n_pass++;
      @(posedge clk);
      @(negedge clk); #1;
      n_total++; if (state !== 6'd0) $display("FAIL br%0d_next act=%0d exp=0", b, state); else n_pass++;
      n_total++; if (retire_cnt !== 8'(b + 1)) $display("FAIL br%0d_retire act=%0d exp=%0d", b, retire_cnt, b + 1); else n_pass++;
      n_total++; if (instruction !== words[b]) $display("FAIL br%0d_ir act=%h exp=%h", b, instruction, words[b]); else n_pass++;
    end
  endtask

  task automatic test_illegal();
    logic [31:0] words[2] = '{32'hFC000000, 32'h0000003F};
    for (int w = 0; w < 2; w++) begin
      do_reset();
      @(negedge clk);
      ir_we = 1'b1; mem_ready = 1'b1; mem_rdata = words[w];
      @(posedge clk);
      @(negedge clk); #1;
      n_total++; if (state !== 6'd1) $display("FAIL ill%0d_id act=%0d exp=1", w, state); else n_pass++;
      @(posedge clk);
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        {ir_we, mem_ready, ben, beqbne, alu_zero} = 5'($urandom);
        pc_we_req = 1'b1; mem_rdata = $urandom;
        #1;
        n_total++; if (state !== 6'd5) $display("FAIL ill%0d_halt act=%0d exp=5", w, state); else n_pass++;
        n_total++; if (illegal !== 1'b1) $display("FAIL ill%0d_flag act=%b exp=1", w, illegal); else n_pass++;
        n_total++; if (pc_en !== 1'b0) $display("FAIL ill%0d_pc_en act=%b exp=0", w, pc_en); else n_pass++;
        n_total++; if (cycle_cnt !== 8'(3 + k)) $display("FAIL ill%0d_cycle act=%0d exp=%0d", w, cycle_cnt, 3 + k); else n_pass++;
        n_total++; if (retire_cnt !== 8'd0) $display("FAIL ill%0d_retire act=%0d exp=0", w, retire_cnt); else n_pass++;
        n_total++; if (instruction !== words[w]) $display("FAIL ill%0d_ir act=%h exp=%h", w, instruction, words[w]); else n_pass++;
        @(posedge clk);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_total++; if (illegal !== 1'b0) $display("FAIL ill%0d_clear act=%b exp=0", w, illegal); else n_pass++;
      n_total++; if (state !== 6'd0) $display("FAIL ill%0d_rst_state act=%0d exp=0", w, state); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_instr(32'h012A4020, 1, 0);
    @(negedge clk);
    ir_we = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h2108000A;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); #1;
    n_total++; if (state !== 6'd2) $display("FAIL mid_exec act=%0d exp=2", state); else n_pass++;
    #1;
    rst_n = 1'b0; mem_rdata = 32'hDEADBEEF;
    #1;
    n_total++; if (state !== 6'd0) $display("FAIL mid_state act=%0d exp=0", state); else n_pass++;
    n_total++; if (retire_cnt !== 8'd0) $display("FAIL mid_retire act=%0d exp=0", retire_cnt); else n_pass++;
    n_total++; if (cycle_cnt !== 8'd0) $display("FAIL mid_cycle act=%0d exp=0", cycle_cnt); else n_pass++;
    n_total++; if (instruction !== 32'd0) $display("FAIL mid_ir act=%h exp=0", instruction); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_instr(32'h08000010, 0, 0);
    run_instr(32'h03E00008, 0, 0);
    run_instr(32'hAD280004, 0, 0);
    run_instr(32'h8D280004, 0, 0);
    @(negedge clk); #1;
    n_total++; if (retire_cnt !== 8'd4) $display("FAIL b2b_retire act=%0d exp=4", retire_cnt); else n_pass++;
    n_total++; if (cycle_cnt !== 8'd15) $display("FAIL b2b_cycle act=%0d exp=15", cycle_cnt); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 300; n++)
      run_instr(rand_legal(), $urandom_range(0, 2), $urandom_range(0, 3));
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_stall();
    test_branch();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not finish, checks %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

endmodule
